autoc_window_acc: RTL
=====================

// Module: autoc_window_acc
// PURPOSE
//  Downstream consumer of the fixed-delay line in the autocorrelation path.
//  - Forms the lag product p = x[n] * conj(x[n-D]) from the live sample and the delayed sample.
//  - Sums p over a sliding window of 2^LOG2_WIN samples.
//  - The output feeds the autocorrelation peak/threshold detector.
//  - Exact arithmetic throughout: no rounding and no saturation.
// PARAMETERS
//  WIDTH     16  bit width of each signed I/Q input component
//  LOG2_WIN  6   log2 of the window length; WIN = 2^LOG2_WIN samples
// PORTS
//  clk        in   1                      system clock, all logic on rising edge
//  rst_n      in   1                      asynchronous active-low reset
//  clear      in   1                      sync clear: empties window, zeroes accumulator
//  stb_in     in   1                      new sample on din_*/dly_* this cycle
//  din_i      in   WIDTH                  live sample I, signed
//  din_q      in   WIDTH                  live sample Q, signed
//  dly_i      in   WIDTH                  delayed sample I, signed (delay-line dout)
//  dly_q      in   WIDTH                  delayed sample Q, signed
//  dly_valid  in   1                      delay-line "outputting"; 0 = dly_* is prefill
//  stb_out    out  1                      acc_* updated this cycle
//  acc_i      out  2*WIDTH+1+LOG2_WIN     window sum, real part, signed
//  acc_q      out  2*WIDTH+1+LOG2_WIN     window sum, imaginary part, signed
//  win_full   out  1                      window holds WIN valid products
// BEHAVIOUR
//  - Reset (rst_n=0, async): all pipeline registers, stb_out, acc_i/q, win_full, fill count and write pointer -> 0.
//  - Accept: a sample is accepted only when stb_in && dly_valid.
//    - stb_in && !dly_valid is dropped: no product, no stb_out.
//  - Pipeline, 3 cycles, accept -> stb_out (fully pipelined, one sample per cycle):
//    - S1 registers the four products i*di, q*dq, q*di, i*dq (2*WIDTH bits each).
//    - S2 forms pr = i*di + q*dq and pq = q*di - i*dq (2*WIDTH+1 bits, sign-extended).
//    - S3 updates acc += p_new - p_old, then pulses stb_out for 1 cycle.
//  - Product buffer: WIN-entry circular RAM of {pr,pq}.
//    - Write pointer advances once per accepted product and wraps WIN-1 -> 0.
//    - p_old is the entry being overwritten.
//  - Fill: count 0..WIN saturates at WIN.
//    - While count < WIN, p_old is forced to 0 because the RAM is never reset.
//    - win_full rises together with the stb_out of the WIN-th product and stays high until clear/reset.
//  - Widths: accumulator width 2*WIDTH+1+LOG2_WIN, which cannot overflow for any input, including -2^(WIDTH-1) on all ports.
//  - Gaps: stb_in may drop at any cycle. The pipeline holds sample order, and nothing advances on idle cycles.
//  - clear:
//    - Takes priority over an accept in the same cycle; that sample is discarded.
//    - In-flight S1/S2 samples are flushed.
//    - Next cycle: acc = 0, win_full = 0, count = 0, pointer = 0, no stb_out.
//  - Reset mid-window: identical to clear, but asynchronous.
//  - dly_valid falling after rising (delay line re-primed): samples are ignored; window contents are kept.
// STRUCTURE
//  - Shared package autoc_pkg: localparams PROD_W = 2*WIDTH+1 and ACC_W = PROD_W+LOG2_WIN; delay/window defaults.
//  - Sub-module autoc_prod_ram: WIN x 2*PROD_W simple dual-port RAM, read-before-write at the same address.
//    - No reset on the memory array, so it maps to block/distributed RAM.
//  - Top level holds the multiplier pipeline, fill counter, pointer and accumulator.
// TESTING
//  - Reset: assert rst_n=0 mid-stream -> all outputs 0 at once.
//    - After release with no stb_in: stb_out stays 0.
//  - Constant tone: LOG2_WIN=6, din=dly=(1000,0), dly_valid=1, 70 strobes:
//    - acc_i steps by 1e6 per stb_out; acc_q = 0.
//    - win_full rises at the 64th stb_out with acc_i = 64e6; acc_i then holds at 64e6.
//  - Quadrature sign: din=(0,1000), dly=(1000,0) -> each product = (0,+1e6).
//    - Swapped, din=(1000,0), dly=(0,1000) -> (0,-1e6).
//  - Extremes: all inputs = -32768 for 64 samples -> acc_i = 64*2^31 = 2^37 exactly, acc_q = 0, no wrap.
//  - Gaps and prefill:
//    - stb_in toggled randomly: results match the reference model sample-for-sample.
//    - Samples with dly_valid=0 produce no stb_out.
//  - Clear: assert clear with stb_in high and 2 samples in flight.
//    - No stb_out follows; acc = 0 and win_full = 0.
//    - Refill then re-reaches 64e6 only after a further 64 samples.

Source files
------------

// File: rtl/autoc_pkg.sv
// +--------------------------------------------------------------------------+
// | autoc_pkg : shared widths and defaults for the autocorrelation path      |
// | Revision  : 1.0                                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

package autoc_pkg;

  localparam int WIDTH_DEF    = 16;
  localparam int LOG2_WIN_DEF = 6;
  localparam int DELAY_DEF    = 16;

  localparam int PROD_W = 2*WIDTH_DEF + 1;
  localparam int ACC_W  = PROD_W + LOG2_WIN_DEF;

  function automatic int prod_width(input int width);
    return 2*width + 1;
  endfunction

  function automatic int acc_width(input int width, input int log2_win);
    return prod_width(width) + log2_win;
  endfunction

endpackage

`default_nettype wire

// File: rtl/autoc_prod_ram.sv
// +--------------------------------------------------------------------------+
// | autoc_prod_ram : simple dual-port product buffer, read-before-write      |
// | Revision       : 1.0                                                     |
// +--------------------------------------------------------------------------+
`default_nettype none

module autoc_prod_ram
  import autoc_pkg::*;
#(
  parameter int ADDR_W = LOG2_WIN_DEF,
  parameter int DATA_W = 2*PROD_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  // No reset on the array so it can map onto RAM primitives.
  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

`default_nettype wire

// File: rtl/autoc_window_acc.sv
// +--------------------------------------------------------------------------+
// | autoc_window_acc : sliding-window sum of x[n]*conj(x[n-D])               |
// | Revision         : 1.0                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module autoc_window_acc
  import autoc_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int LOG2_WIN = LOG2_WIN_DEF
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        clear,
  input  logic                                        stb_in,
  input  logic signed [WIDTH-1:0]                     din_i,
  input  logic signed [WIDTH-1:0]                     din_q,
  input  logic signed [WIDTH-1:0]                     dly_i,
  input  logic signed [WIDTH-1:0]                     dly_q,
  input  logic                                        dly_valid,
  output logic                                        stb_out,
  output logic signed [acc_width(WIDTH,LOG2_WIN)-1:0] acc_i,
  output logic signed [acc_width(WIDTH,LOG2_WIN)-1:0] acc_q,
  output logic                                        win_full
);

  localparam int MW = 2*WIDTH;
  localparam int PW = prod_width(WIDTH);
  localparam int AW = acc_width(WIDTH, LOG2_WIN);

  logic                    accept;
  logic                    v1, v2;
  logic signed [MW-1:0]    m_ii, m_qq, m_qi, m_iq;
  logic signed [PW-1:0]    pr, pq;
  logic signed [PW-1:0]    old_pr, old_pq;
  logic [LOG2_WIN-1:0]     wr_ptr, rd_addr;
  logic [LOG2_WIN:0]       fill_cnt;
  logic                    last_fill;
  logic [2*PW-1:0]         rd_data;

  assign accept    = stb_in & dly_valid & ~clear;
  assign last_fill = ~fill_cnt[LOG2_WIN] & (&fill_cnt[LOG2_WIN-1:0]);

  // The S1 sample lands one slot past the S2 sample still waiting to be written.
  assign rd_addr = v2 ? wr_ptr + LOG2_WIN'(1) : wr_ptr;

  // Until the window has wrapped once the RAM holds garbage, not old products.
  assign old_pr = fill_cnt[LOG2_WIN] ? rd_data[2*PW-1:PW] : '0;
  assign old_pq = fill_cnt[LOG2_WIN] ? rd_data[PW-1:0]    : '0;

  autoc_prod_ram #(
    .ADDR_W (LOG2_WIN),
    .DATA_W (2*PW)
  ) u_ram (
    .clk   (clk),
    .we    (v2 & ~clear),
    .waddr (wr_ptr),
    .wdata ({pr, pq}),
    .re    (v1),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1   <= 1'b0;
      m_ii <= '0;
      m_qq <= '0;
      m_qi <= '0;
      m_iq <= '0;
    end else begin
      v1 <= accept;
      if (accept) begin
        m_ii <= MW'(din_i) * MW'(dly_i);
        m_qq <= MW'(din_q) * MW'(dly_q);
        m_qi <= MW'(din_q) * MW'(dly_i);
        m_iq <= MW'(din_i) * MW'(dly_q);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2 <= 1'b0;
      pr <= '0;
      pq <= '0;
    end else begin
      v2 <= v1 & ~clear;
      if (v1) begin
        pr <= PW'(m_ii) + PW'(m_qq);
        pq <= PW'(m_qi) - PW'(m_iq);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stb_out  <= 1'b0;
      acc_i    <= '0;
      acc_q    <= '0;
      win_full <= 1'b0;
      fill_cnt <= '0;
      wr_ptr   <= '0;
    end else if (clear) begin
      stb_out  <= 1'b0;
      acc_i    <= '0;
      acc_q    <= '0;
      win_full <= 1'b0;
      fill_cnt <= '0;
      wr_ptr   <= '0;
    end else begin
      stb_out <= v2;
      if (v2) begin
        acc_i  <= acc_i + AW'(pr) - AW'(old_pr);
        acc_q  <= acc_q + AW'(pq) - AW'(old_pq);
        wr_ptr <= wr_ptr + LOG2_WIN'(1);
        if (!fill_cnt[LOG2_WIN]) fill_cnt <= fill_cnt + (LOG2_WIN+1)'(1);
        if (last_fill) win_full <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire
